// File: rtl/clk_enable_bank_pkg.sv
// Shared types and sizing helpers for the clock-enable bank.
package clk_enable_bank_pkg;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } bank_state_t;

    // Width of a counter that must hold 0 .. cycles-1.
    function automatic int lock_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    // Width of a channel index for n channels.
    function automatic int chan_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_enable_channel.sv
// One divided-clock channel: wrap counter, terminal-count strobe and square toggle.
module clk_enable_channel #(
    parameter int DIV_W = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             clk_en,
    output logic             clk_sq
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] term;
    logic             sq_q;
    logic             at_term;

    // Ratios 0 and 1 both mean "strobe every cycle"; the clamp keeps div-1 from wrapping.
    always_comb begin
        term = '0;
        if (div > DIV_W'(1)) begin
            term = div - DIV_W'(1);
        end
    end

    assign at_term = (cnt_q == term);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else if (!run) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else if (at_term) begin
            cnt_q <= '0;
            sq_q  <= ~sq_q;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

    // Gating with run silences the square wave in the very cycle the bank unlocks.
    assign clk_en = run & at_term;
    assign clk_sq = run & sq_q;

endmodule

// File: rtl/clk_enable_bank.sv
// Bank of phase-aligned clock-enable channels with a settle/lock sequencer.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_SETTLE | channels held at 0, lock counter runs for LOCK_CYCLES
//   ST_LOCKED | channels running together, reconfiguration accepted
module clk_enable_bank
    import clk_enable_bank_pkg::*;
#(
    parameter int NUM_CLOCKS  = 3,
    parameter int DIV_W       = 8,
    parameter int DIV_RESET   = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                                refclk,
    input  logic                                rst_n,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [chan_width(NUM_CLOCKS)-1:0]   cfg_chan,
    input  logic [DIV_W-1:0]                    cfg_div,
    output logic [NUM_CLOCKS-1:0]               clk_en,
    output logic [NUM_CLOCKS-1:0]               clk_sq,
    output logic                                locked
);

    localparam int CHAN_W = chan_width(NUM_CLOCKS);
    localparam int LCNT_W = lock_cnt_width(LOCK_CYCLES);
    localparam logic [LCNT_W-1:0] LOCK_TERM = LCNT_W'(LOCK_CYCLES - 1);

    bank_state_t       state_q;
    logic [LCNT_W-1:0] lock_cnt_q;
    logic              locked_q;
    logic              ready_q;
    logic [DIV_W-1:0]  div_q [NUM_CLOCKS];

    logic cfg_hit;
    logic cfg_in_range;
    logic cfg_apply;

    assign cfg_hit      = cfg_valid & ready_q;
    assign cfg_in_range = (int'(cfg_chan) < NUM_CLOCKS);
    assign cfg_apply    = cfg_hit & cfg_in_range;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SETTLE;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (lock_cnt_q == LOCK_TERM) begin
                        state_q    <= ST_LOCKED;
                        lock_cnt_q <= '0;
                        locked_q   <= 1'b1;
                        ready_q    <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LCNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Out-of-range channel requests are consumed without disturbing lock.
                    if (cfg_apply) begin
                        state_q    <= ST_SETTLE;
                        lock_cnt_q <= '0;
                        locked_q   <= 1'b0;
                        ready_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_SETTLE;
                    lock_cnt_q <= '0;
                    locked_q   <= 1'b0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                div_q[i] <= DIV_W'(DIV_RESET);
            end
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (cfg_apply && (cfg_chan == CHAN_W'(i))) begin
                    div_q[i] <= cfg_div;
                end
            end
        end
    end

    // All channels share one run signal, so they leave reset-hold on the same edge.
    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        clk_enable_channel #(
            .DIV_W(DIV_W)
        ) u_chan (
            .refclk(refclk),
            .rst_n (rst_n),
            .run   (locked_q),
            .div   (div_q[g]),
            .clk_en(clk_en[g]),
            .clk_sq(clk_sq[g])
        );
    end

    assign locked    = locked_q;
    assign cfg_ready = ready_q;

endmodule

// File: tb/tb_clk_enable_bank.sv
// Randomized bench for clk_enable_bank against a time-since-lock arithmetic model.
module tb_clk_enable_bank;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int DR = 2;
    localparam int LC = 16;

    logic          refclk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan = '0;
    logic [DW-1:0] cfg_div = '0;
    logic [N-1:0]  clk_en;
    logic [N-1:0]  clk_sq;
    logic          locked;

    clk_enable_bank #(
        .NUM_CLOCKS (N),
        .DIV_W      (DW),
        .DIV_RESET  (DR),
        .LOCK_CYCLES(LC)
    ) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_div  (cfg_div),
        .clk_en   (clk_en),
        .clk_sq   (clk_sq),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: lock flag, edges spent settling, edges since lock, divider values.
    bit m_locked;
    int m_settle;
    int m_t;
    int m_cyc;
    int m_div [N];
    bit m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_locked = 1'b0;
        m_settle = 0;
        m_t      = 0;
        m_cyc    = 0;
        m_acc    = 1'b0;
        for (int i = 0; i < N; i++) m_div[i] = DR;
    endfunction

    function automatic void model_edge();
        m_acc = 1'b0;
        if (!rst_n) return;
        m_cyc++;
        if (!m_locked) begin
            if (m_settle == LC - 1) begin
                m_locked = 1'b1;
                m_t      = 0;
            end else begin
                m_settle++;
            end
        end else begin
            if (cfg_valid) begin
                m_acc = 1'b1;
                if (int'(cfg_chan) < N) begin
                    m_div[cfg_chan] = int'(cfg_div);
                    m_locked = 1'b0;
                    m_settle = 0;
                end
            end
            if (m_locked) m_t++;
        end
    endfunction

    function automatic logic [N-1:0] exp_en();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (m_div[i] <= 1) ? 1 : m_div[i];
            r[i] = m_locked && ((m_t % d) == d - 1);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_sq();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (m_div[i] <= 1) ? 1 : m_div[i];
            r[i] = m_locked && (((m_t / d) % 2) == 1);
        end
        return r;
    endfunction

    task automatic check_all();
        chk("locked", 32'(locked), 32'(m_locked));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_locked));
        chk("clk_en", 32'(clk_en), 32'(exp_en()));
        chk("clk_sq", 32'(clk_sq), 32'(exp_sq()));
    endtask

    task automatic tick();
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
        check_all();
    endtask

    task automatic do_reset(input int hold);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_en", 32'(clk_en), 32'd0);
        chk("rst_sq", 32'(clk_sq), 32'd0);
        for (int k = 0; k < hold; k++) tick();
        rst_n = 1'b1;
    endtask

    task automatic boot_run();
        for (int k = 0; k < 40; k++) begin
            tick();
            case (m_cyc)
                15: chk("boot_lock_c15", 32'(locked), 32'd0);
                16: chk("boot_lock_c16", 32'(locked), 32'd1);
                17: chk("boot_en_c17", 32'(clk_en), 32'b111);
                18: begin
                    chk("boot_en_c18", 32'(clk_en), 32'b000);
                    chk("boot_sq_c18", 32'(clk_sq), 32'b111);
                end
                19: chk("boot_en_c19", 32'(clk_en), 32'b111);
                20: chk("boot_sq_c20", 32'(clk_sq), 32'b000);
                default: ;
            endcase
        end
    endtask

    task automatic send_cfg(input logic [1:0] c, input logic [DW-1:0] d);
        int k;
        cfg_valid = 1'b1;
        cfg_chan  = c;
        cfg_div   = d;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_acc && k < 100);
        cfg_valid = 1'b0;
        chk("cfg_accept", 32'(m_acc), 32'd1);
    endtask

    task automatic wait_lock(output int gap);
        gap = 0;
        while (!locked && gap < 100) begin
            tick();
            gap++;
        end
        chk("wait_lock", 32'(locked), 32'd1);
    endtask

    initial begin
        int gap;
        int strobes;
        m_reset();
        #2;
        do_reset(3);
        boot_run();

        // Reprogram channel 1 to divide by 5.
        send_cfg(2'd1, 8'd5);
        chk("cfg_drop_locked", 32'(locked), 32'd0);
        wait_lock(gap);
        chk("relock_gap", 32'(gap), 32'd16);
        chk("align_en", 32'(clk_en), 32'b000);
        chk("align_sq", 32'(clk_sq), 32'b000);
        tick();
        chk("div5_t1_en", 32'(clk_en), 32'b101);
        tick(); tick(); tick();
        chk("div5_t4_en", 32'(clk_en), 32'b010);
        for (int k = 0; k < 30; k++) tick();

        // Out-of-range channel: consumed, lock untouched.
        send_cfg(2'd3, 8'd7);
        chk("bad_chan_locked", 32'(locked), 32'd1);
        for (int k = 0; k < 12; k++) tick();

        send_cfg(2'd0, 8'd0);
        wait_lock(gap);
        for (int k = 0; k < 6; k++) tick();
        chk("div0_en", 32'(clk_en[0]), 32'd1);
        send_cfg(2'd0, 8'd1);
        wait_lock(gap);
        for (int k = 0; k < 7; k++) tick();
        chk("div1_en", 32'(clk_en[0]), 32'd1);

        send_cfg(2'd2, 8'd255);
        wait_lock(gap);
        strobes = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (clk_en[2]) strobes++;
        end
        chk("div255_strobes", 32'(strobes), 32'd2);

        // Reset during settle discards the reprogrammed dividers.
        send_cfg(2'd1, 8'd9);
        for (int k = 0; k < 8; k++) tick();
        do_reset(3);
        boot_run();

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 3));
            end else if (!cfg_valid && $urandom_range(0, 15) == 0) begin
                cfg_valid = 1'b1;
                cfg_chan  = 2'($urandom_range(0, 3));
                cfg_div   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                        : 8'($urandom_range(0, 6));
            end
            tick();
            if (m_acc) cfg_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_enable_bank.md
CLK_ENABLE_BANK -- requirements
Module: clk_enable_bank

Interface
REQ-001 The module SHALL have parameter NUM_CLOCKS, default 3, giving the number of output channels (1..18).
REQ-002 The module SHALL have parameter DIV_W, default 8, giving the divider register width.
REQ-003 The module SHALL have parameter DIV_RESET, default 2, giving the divide ratio every channel loads at reset.
REQ-004 The module SHALL have parameter LOCK_CYCLES, default 16, giving the settle time in refclk cycles before locked asserts (>=1).
REQ-005 The module SHALL use one clock and an asynchronous, active-low reset; the ports are named refclk and rst_n.
REQ-006 Port refclk: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-008 Port cfg_valid: input, 1 bit, reconfiguration request.
REQ-009 Port cfg_ready: output, 1 bit, a request is accepted on the cycle where cfg_valid and cfg_ready are both 1.
REQ-010 Port cfg_chan: input, max(1,clog2(NUM_CLOCKS)) bits, index of the channel to reprogram.
REQ-011 Port cfg_div: input, DIV_W bits, new divide ratio.
REQ-012 Port clk_en: output, NUM_CLOCKS bits, one-cycle enable strobe per channel.
REQ-013 Port clk_sq: output, NUM_CLOCKS bits, 50%-duty square wave per channel with period 2*div.
REQ-014 Port locked: output, 1 bit, all channels are running and phase-aligned.

Function
REQ-015 The FSM SHALL have two states: SETTLE and LOCKED. Reset enters SETTLE.
- SETTLE: locked=0, cfg_ready=0; lock counter increments each cycle.
- The FSM SHALL move to LOCKED on the edge where the lock counter reaches LOCK_CYCLES-1.
- LOCKED: locked=1, cfg_ready=1.
REQ-016 locked SHALL first read 1 in cycle LOCK_CYCLES, where cycle 0 is the first rising edge with rst_n high.
REQ-017 When not LOCKED, each channel SHALL hold its counter at 0, clk_en[i]=0 and clk_sq[i]=0.
REQ-018 On entering LOCKED, all channel counters SHALL start from 0 together, so the channels are phase-aligned.
REQ-019 While LOCKED, channel i SHALL count 0..div_i-1 and wrap.
- clk_en[i]=1 exactly in the cycle where the count equals div_i-1.
- clk_sq[i] toggles on the edge following each strobe.
REQ-020 A div value of 0 or 1 SHALL be treated as 1, giving clk_en[i]=1 continuously while locked and clk_sq[i] toggling every cycle.
REQ-021 The first strobe of channel i SHALL occur div_i-1 cycles after locked rises (in the same cycle as the rise when div_i=1).
REQ-022 An accepted request with cfg_chan < NUM_CLOCKS SHALL, on the next edge:
- write cfg_div to divider i;
- return the FSM to SETTLE, dropping locked and cfg_ready and clearing the lock counter;
- stop all channels (REQ-017).
REQ-023 An accepted request with cfg_chan >= NUM_CLOCKS SHALL be discarded, with no state change and no drop of locked.
REQ-024 cfg_valid while cfg_ready=0 SHALL be ignored; requesters hold cfg_valid until accepted.
REQ-025 Counter width SHALL be DIV_W bits; comparison uses div_i-1 computed in DIV_W bits after the 0->1 clamp, so there is no overflow at div = 2^DIV_W-1.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear:
- state to SETTLE and the lock counter to 0;
- locked, cfg_ready, clk_en and clk_sq to 0;
- every divider to DIV_RESET.
REQ-027 Reset asserted mid-SETTLE (including after a reconfiguration) SHALL discard the reprogrammed dividers and restart settle from cycle 0 on release.

Structure
REQ-028 Package clk_enable_bank_pkg SHALL hold the FSM state enum and a lock-counter-width helper constant/function.
REQ-029 Per-channel logic SHALL be sub-module clk_enable_channel (counter, strobe, square toggle, run input), instantiated NUM_CLOCKS times by a generate loop.

Verification
REQ-030 Reset release, defaults (NUM_CLOCKS=3, DIV_RESET=2, LOCK_CYCLES=16) -> locked=0 for cycles 0..15, locked=1 at cycle 16; clk_en=3'b111 at cycles 17, 19, 21...; clk_sq period 4 on all channels.
REQ-031 In LOCKED, write chan=1, div=5 -> locked=0 next cycle, relocks 16 cycles later. Then:
- clk_en[1] strobes every 5 cycles, first strobe 4 cycles after lock;
- channels 0 and 2 strobe every 2 cycles;
- all channels are aligned at the lock edge.
REQ-032 Write chan=3, div=7 with NUM_CLOCKS=3 -> accepted, locked stays 1, no output phase change.
REQ-033 Write div=0 and div=1 to channel 0 -> clk_en[0] constantly 1 after relock; clk_sq[0] toggles every cycle.
REQ-034 Write div=255 (DIV_W=8) -> strobe every 255 cycles, no wrap glitch.
REQ-035 Reset pulse 8 cycles after reconfiguration -> all outputs 0 at once; after release, all channels run at div=2 and lock at cycle 16.
